// File: rtl/ctn_pkg.sv
// Shared definitions for the third-level cache controller.
// Holds the FSM state encoding, the memory-side mux encodings, the default
// fill timeout and the packed bundle of registered control outputs.
package ctn_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    // Sel_Mux_Mem encodings
    localparam logic [1:0] MEM_BANK   = 2'b00;
    localparam logic [1:0] MEM_VICTIM = 2'b01;
    localparam logic [1:0] MEM_REQ    = 2'b10;

    typedef enum logic [3:0] {
        INIT       = 4'd0,
        IDLE       = 4'd1,
        LOAD       = 4'd2,
        LOOKUP     = 4'd3,
        RD_OUT     = 4'd4,
        WR_BYTE    = 4'd5,
        EVICT      = 4'd6,
        REQ_FILL   = 4'd7,
        WAIT_FILL  = 4'd8,
        FILL       = 4'd9,
        WRITE_LINE = 4'd10
    } state_t;

    // All outputs of the controller, registered together
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       error;
        logic       push;
        logic       pop;
        logic       lect_esc;
        logic       clr_main;
        logic       en_main;
        logic       sel_bank;
        logic       clr_tag;
        logic       r_w;
        logic       clr_form;
        logic       en_form;
        logic       bank_en;
        logic       wr_en;
        logic       clr_ldg;
        logic       en_reg;
        logic [1:0] sel_mem;
    } ctrl_t;

endpackage

// File: rtl/ctn_timeout_counter.sv
// Fill-wait timeout counter.
// Ports: clk/rst (async active-high), clr (synchronous clear, wins over en),
// en (count up by one), tc (count has reached TIMEOUT_CYCLES-1).
module ctn_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/control_tercer_nivel.sv
// Third-level cache access controller.
// Sequences a byte read/write against the data banks; on a miss it pushes the
// dirty victim (if any) and a line request into the lower-level FIFO, waits
// (bounded) for the returned line, writes it into the banks and replays the
// access.
// Ports: CLK, Reset (async active-high); Req/Req_RW from the upper level;
// Hit/Desalojo from the datapath; Push_Full/Pop_Empty from the lower-level
// FIFO; Busy/Done/Error status; Push/Pop FIFO strobes; datapath controls.
// All outputs are registered: each reflects the state of the previous cycle
// (Busy reflects the current state), so Reset zeroes them immediately.
module control_tercer_nivel
    import ctn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Req,
    input  logic       Req_RW,
    input  logic       Hit,
    input  logic       Desalojo,
    input  logic       Push_Full,
    input  logic       Pop_Empty,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic       Push,
    output logic       Pop,
    output logic       Lectura_Escritura,
    output logic       Clear_Main_REG,
    output logic       Eneable_Main_REG,
    output logic       Sel_Mux_Bank,
    output logic       Clear_Tag_Banks,
    output logic       R_W,
    output logic       Clear_Formador,
    output logic       Eneable_Formador,
    output logic       Bank_Eneable,
    output logic       Write_Eneable,
    output logic       Clear_LDG_REG,
    output logic       Eneable_REG,
    output logic [1:0] Sel_Mux_Mem
);

    state_t state_q;
    state_t state_d;
    logic   rw_q;
    logic   rw_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   tmo_tc;

    ctn_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (CLK),
        .rst (Reset),
        .clr (state_q != WAIT_FILL),
        .en  (state_q == WAIT_FILL),
        .tc  (tmo_tc)
    );

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        ctrl_d  = '0;
        case (state_q)
            INIT: begin
                ctrl_d.clr_main = 1'b1;
                ctrl_d.clr_tag  = 1'b1;
                ctrl_d.clr_form = 1'b1;
                ctrl_d.clr_ldg  = 1'b1;
                state_d         = IDLE;
            end
            IDLE: begin
                if (Req) begin
                    rw_d    = Req_RW;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                ctrl_d.en_main  = 1'b1;
                ctrl_d.lect_esc = 1'b0;
                state_d         = LOOKUP;
            end
            LOOKUP: begin
                if (Hit) begin
                    state_d = rw_q ? WR_BYTE : RD_OUT;
                end else if (Desalojo) begin
                    state_d = EVICT;
                end else begin
                    state_d = REQ_FILL;
                end
            end
            RD_OUT: begin
                ctrl_d.en_reg = 1'b1;
                ctrl_d.r_w    = 1'b0;
                ctrl_d.done   = 1'b1;
                state_d       = IDLE;
            end
            WR_BYTE: begin
                ctrl_d.en_form  = 1'b1;
                ctrl_d.bank_en  = 1'b1;
                ctrl_d.wr_en    = 1'b1;
                ctrl_d.r_w      = 1'b1;
                ctrl_d.sel_bank = 1'b0;
                ctrl_d.done     = 1'b1;
                state_d         = IDLE;
            end
            EVICT: begin
                ctrl_d.sel_mem = MEM_VICTIM;
                // Push is issued on the single cycle the FIFO can accept it
                if (!Push_Full) begin
                    ctrl_d.push = 1'b1;
                    state_d     = REQ_FILL;
                end else begin
                    state_d = EVICT;
                end
            end
            REQ_FILL: begin
                ctrl_d.sel_mem = MEM_REQ;
                if (!Push_Full) begin
                    ctrl_d.push = 1'b1;
                    state_d     = WAIT_FILL;
                end else begin
                    state_d = REQ_FILL;
                end
            end
            WAIT_FILL: begin
                // Arriving data beats a timeout in the same cycle
                if (!Pop_Empty) begin
                    state_d = FILL;
                end else if (tmo_tc) begin
                    ctrl_d.error = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT_FILL;
                end
            end
            FILL: begin
                ctrl_d.pop      = 1'b1;
                ctrl_d.en_main  = 1'b1;
                ctrl_d.lect_esc = 1'b1;
                state_d         = WRITE_LINE;
            end
            WRITE_LINE: begin
                ctrl_d.bank_en  = 1'b1;
                ctrl_d.wr_en    = 1'b1;
                ctrl_d.sel_bank = 1'b1;
                state_d         = LOAD;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // Busy follows the state being entered so it is low exactly in IDLE
        ctrl_d.busy = (state_d != IDLE) && (state_d != INIT);
    end

    // State, latched access type and registered outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= INIT;
            rw_q    <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign Busy              = ctrl_q.busy;
    assign Done              = ctrl_q.done;
    assign Error             = ctrl_q.error;
    assign Push              = ctrl_q.push;
    assign Pop               = ctrl_q.pop;
    assign Lectura_Escritura = ctrl_q.lect_esc;
    assign Clear_Main_REG    = ctrl_q.clr_main;
    assign Eneable_Main_REG  = ctrl_q.en_main;
    assign Sel_Mux_Bank      = ctrl_q.sel_bank;
    assign Clear_Tag_Banks   = ctrl_q.clr_tag;
    assign R_W               = ctrl_q.r_w;
    assign Clear_Formador    = ctrl_q.clr_form;
    assign Eneable_Formador  = ctrl_q.en_form;
    assign Bank_Eneable      = ctrl_q.bank_en;
    assign Write_Eneable     = ctrl_q.wr_en;
    assign Clear_LDG_REG     = ctrl_q.clr_ldg;
    assign Eneable_REG       = ctrl_q.en_reg;
    assign Sel_Mux_Mem       = ctrl_q.sel_mem;

endmodule

// File: tb/tb_control_tercer_nivel.sv
// Self-checking bench for control_tercer_nivel.
// Each access is described at transaction level (read/write, hit, dirty,
// FIFO-full stall lengths, fill delay). The expected cycle of every output
// event is derived from the access rules with plain latency arithmetic,
// counted from the cycle in which Req is presented (cycle 0).
module tb_control_tercer_nivel;

    localparam int T = 8;

    logic       CLK       = 1'b0;
    logic       Reset     = 1'b1;
    logic       Req       = 1'b0;
    logic       Req_RW    = 1'b0;
    logic       Hit       = 1'b0;
    logic       Desalojo  = 1'b0;
    logic       Push_Full = 1'b0;
    logic       Pop_Empty = 1'b1;
    logic       Busy, Done, Error, Push, Pop;
    logic       Lectura_Escritura, Clear_Main_REG, Eneable_Main_REG, Sel_Mux_Bank;
    logic       Clear_Tag_Banks, R_W, Clear_Formador, Eneable_Formador;
    logic       Bank_Eneable, Write_Eneable, Clear_LDG_REG, Eneable_REG;
    logic [1:0] Sel_Mux_Mem;

    int n_cmp = 0;
    int n_bad = 0;

    control_tercer_nivel #(.TIMEOUT_CYCLES(T)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .Req              (Req),
        .Req_RW           (Req_RW),
        .Hit              (Hit),
        .Desalojo         (Desalojo),
        .Push_Full        (Push_Full),
        .Pop_Empty        (Pop_Empty),
        .Busy             (Busy),
        .Done             (Done),
        .Error            (Error),
        .Push             (Push),
        .Pop              (Pop),
        .Lectura_Escritura(Lectura_Escritura),
        .Clear_Main_REG   (Clear_Main_REG),
        .Eneable_Main_REG (Eneable_Main_REG),
        .Sel_Mux_Bank     (Sel_Mux_Bank),
        .Clear_Tag_Banks  (Clear_Tag_Banks),
        .R_W              (R_W),
        .Clear_Formador   (Clear_Formador),
        .Eneable_Formador (Eneable_Formador),
        .Bank_Eneable     (Bank_Eneable),
        .Write_Eneable    (Write_Eneable),
        .Clear_LDG_REG    (Clear_LDG_REG),
        .Eneable_REG      (Eneable_REG),
        .Sel_Mux_Mem      (Sel_Mux_Mem)
    );

    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // One access. abort_k >= 0 asserts Reset at that cycle instead of finishing.
    task automatic run_txn(input logic rw, input logic hit, input logic dirty,
                           input int f1, input int f2, input int d,
                           input int abort_k, input string tag);
        int ev_acc, rf, rf_acc, w, done_c, err_c, pop_c, wl_c, end_c;
        bit filled;
        logic [13:0] obs, exp_v;
        logic [1:0]  exp_sel;
        ev_acc = -1; rf = -1; rf_acc = -1; w = -1;
        done_c = -1; err_c = -1; pop_c = -1; wl_c = -1;
        filled = 1'b0;
        if (hit) begin
            done_c = 4;
        end else begin
            if (dirty) begin
                ev_acc = 3 + f1;
                rf     = 4 + f1;
            end else begin
                rf = 3;
            end
            rf_acc = rf + f2;
            w      = rf_acc + 1;
            if (d < T) begin
                filled = 1'b1;
                pop_c  = w + d + 2;
                wl_c   = w + d + 3;
                done_c = w + d + 6;
            end else begin
                err_c = w + T;
            end
        end
        end_c = (done_c >= 0) ? done_c : err_c;

        for (int k = 0; k <= end_c; k++) begin
            @(negedge CLK);
            obs = {Done, Error, Push, Pop, Busy, Write_Eneable, Bank_Eneable,
                   Sel_Mux_Bank, R_W, Eneable_REG, Lectura_Escritura,
                   Eneable_Main_REG, Eneable_Formador,
                   (Clear_Main_REG | Clear_Tag_Banks | Clear_Formador | Clear_LDG_REG)};
            exp_v[13] = (k == done_c);
            exp_v[12] = (k == err_c);
            exp_v[11] = (ev_acc >= 0 && k == ev_acc + 1) || (rf_acc >= 0 && k == rf_acc + 1);
            exp_v[10] = (k == pop_c);
            exp_v[9]  = (k >= 1 && k < end_c);
            exp_v[8]  = (k == wl_c) || (rw && k == done_c);
            exp_v[7]  = (k == wl_c) || (rw && k == done_c);
            exp_v[6]  = (k == wl_c);
            exp_v[5]  = rw && (k == done_c);
            exp_v[4]  = !rw && (k == done_c);
            exp_v[3]  = (k == pop_c);
            exp_v[2]  = (k == 2) || (k == pop_c) || (filled && k == w + d + 4);
            exp_v[1]  = rw && (k == done_c);
            exp_v[0]  = 1'b0;
            if (ev_acc >= 0 && k >= 4 && k <= ev_acc + 1)
                exp_sel = 2'b01;
            else if (rf >= 0 && k >= rf + 1 && k <= rf_acc + 1)
                exp_sel = 2'b10;
            else
                exp_sel = 2'b00;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s ctrl cycle %0d: got %b expected %b (Done,Error,Push,Pop,Busy,WE,BE,SelBank,RW,EnREG,LE,EnMain,EnForm,Clr)",
                         tag, k, obs, exp_v);
            end
            n_cmp++;
            if (Sel_Mux_Mem !== exp_sel) begin
                n_bad++;
                $display("FAIL %s sel_mux_mem cycle %0d: got %b expected %b", tag, k, Sel_Mux_Mem, exp_sel);
            end

            if (k == abort_k) begin
                Reset = 1'b1;
                Req = 1'b0; Hit = 1'b0; Push_Full = 1'b0; Pop_Empty = 1'b1;
                #1;
                n_cmp++;
                if ({Busy, Done, Error, Push, Pop} !== 5'b00000) begin
                    n_bad++;
                    $display("FAIL %s reset_immediate: got %b expected 00000", tag, {Busy, Done, Error, Push, Pop});
                end
                repeat (2) begin
                    @(negedge CLK);
                    n_cmp++;
                    if ({Done, Error, Push, Pop} !== 4'b0000) begin
                        n_bad++;
                        $display("FAIL %s reset_hold: got %b expected 0000", tag, {Done, Error, Push, Pop});
                    end
                end
                Reset = 1'b0;
                @(negedge CLK);
                n_cmp++;
                if ({Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Done, Error} !== 6'b111100) begin
                    n_bad++;
                    $display("FAIL %s init_after_abort: got %b expected 111100", tag,
                             {Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Done, Error});
                end
                @(negedge CLK);
                n_cmp++;
                if ({Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy} !== 5'b00000) begin
                    n_bad++;
                    $display("FAIL %s init_one_cycle: got %b expected 00000", tag,
                             {Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy});
                end
                return;
            end

            // Inputs for cycle k; stray Req while busy must be ignored
            Req       = (k == 0) ? 1'b1 : ((k < end_c) ? 1'($urandom_range(0, 1)) : 1'b0);
            Req_RW    = (k == 0) ? rw : 1'($urandom_range(0, 1));
            Hit       = hit || (filled && k > w + d);
            Desalojo  = dirty;
            if (ev_acc >= 0 && k >= 3 && k <= ev_acc)
                Push_Full = (k < ev_acc);
            else if (rf >= 0 && k >= rf && k <= rf_acc)
                Push_Full = (k < rf_acc);
            else
                Push_Full = 1'($urandom_range(0, 1));
            if (w >= 0 && k >= w && k < w + T)
                Pop_Empty = !(filled && k == w + d);
            else
                Pop_Empty = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({Busy, Done, Error, Push, Pop, Clear_Main_REG, Clear_Tag_Banks, Write_Eneable, Sel_Mux_Mem} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {Busy, Done, Error, Push, Pop, Clear_Main_REG, Clear_Tag_Banks, Write_Eneable, Sel_Mux_Mem});
        end
        Reset = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy, Done} !== 6'b111100) begin
            n_bad++;
            $display("FAIL init_clears: got %b expected 111100",
                     {Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy, Done});
        end
        @(negedge CLK);
        n_cmp++;
        if ({Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy} !== 5'b00000) begin
            n_bad++;
            $display("FAIL init_one_cycle: got %b expected 00000",
                     {Clear_Main_REG, Clear_Tag_Banks, Clear_Formador, Clear_LDG_REG, Busy});
        end
    endtask

    task automatic test_read_hit();
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 0, -1, "read_hit");
    endtask

    task automatic test_write_hit();
        run_txn(1'b1, 1'b1, 1'b1, 0, 0, 0, -1, "write_hit");
    endtask

    task automatic test_dirty_miss();
        run_txn(1'b0, 1'b0, 1'b1, 3, 0, 2, -1, "dirty_miss");
        run_txn(1'b1, 1'b0, 1'b1, 1, 2, 0, -1, "dirty_miss_wr");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 1'b0, 0, 0, T, -1, "timeout");
        run_txn(1'b1, 1'b0, 1'b0, 0, 1, T - 1, -1, "fill_beats_timeout");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 0, -1, "b2b_a");
        run_txn(1'b1, 1'b1, 1'b0, 0, 0, 0, -1, "b2b_b");
        run_txn(1'b0, 1'b1, 1'b1, 0, 0, 0, -1, "b2b_c");
    endtask

    task automatic test_reset_wait_fill();
        // Clean miss, one stall on REQ_FILL: WAIT_FILL starts at cycle 5
        run_txn(1'b0, 1'b0, 1'b0, 0, 1, T + 4, 8, "reset_wait_fill");
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)),
                    -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_timeout();
        test_back_to_back();
        test_reset_wait_fill();
        test_random();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
